floor_controller: RTL and testbench
===================================

FLOOR_CONTROLLER -- requirements
Module: floor_controller

Interface
REQ-001 SHALL have parameter TRAVEL_CYCLES, default 4, giving the clock cycles to travel one floor (legal range 1..255).
REQ-002 SHALL have parameter DOOR_CYCLES, default 8, giving the clock cycles the door stays open (legal range 1..255).
REQ-003 SHALL have parameters ST_FLOOR=2'b00, ND_FLOOR=2'b01 and RD_FLOOR=2'b10 as the floor codes.
REQ-004 SHALL use one clock, with reset synchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-007 SHALL have port open_when, input, 2 bits, the target floor chosen by the request scheduler.
REQ-008 SHALL have port req_valid, input, 1 bit, asserted when open_when holds a pending request.
REQ-009 SHALL have port floor, output, 2 bits, the current cabin floor (registered).
REQ-010 SHALL have port is_mooving, output, 1 bit, high while the cabin travels (registered).
REQ-011 SHALL have port door_open, output, 1 bit, high while the door is open (registered).
REQ-012 SHALL have port served, output, 3 bits, a one-hot one-cycle pulse {st,nd,rd} that clears the request LED of the floor just reached.

Function
REQ-013 SHALL implement three states: IDLE, MOVE and DOOR.
REQ-014 In IDLE with req_valid=1 and open_when==floor, SHALL enter DOOR on the next edge: door_open=1, served pulses the bit for floor.
REQ-015 In IDLE with req_valid=1 and a legal open_when!=floor, SHALL on the next edge enter MOVE, set is_mooving=1, latch open_when as target and clear the cycle counter.
REQ-016 SHALL ignore open_when=2'b11 (illegal): remain in IDLE with no output change.
REQ-017 In MOVE, SHALL increment the cycle counter each cycle; when counter==TRAVEL_CYCLES-1 it SHALL step floor by ±1 toward the target and clear the counter.
REQ-018 SHALL travel one floor every TRAVEL_CYCLES cycles; 00->10 passes 01 and takes 2*TRAVEL_CYCLES cycles.
REQ-019 On the edge where floor becomes target, SHALL set is_mooving=0 and door_open=1, pulse served for target, and enter DOOR, all on that same edge.
REQ-020 During MOVE, SHALL ignore changes on open_when and req_valid; the target is fixed until arrival.
REQ-021 In DOOR, SHALL hold door_open=1 for exactly DOOR_CYCLES cycles, then clear door_open and enter IDLE.
REQ-022 SHALL accept no request in the cycle door_open falls; the earliest new acceptance is the following edge.
REQ-023 served SHALL be high for exactly one cycle per arrival, and 000 otherwise.
REQ-024 is_mooving and door_open SHALL never both be 1.
REQ-025 floor SHALL never take the value 2'b11.
REQ-026 The counter SHALL be 8 bits wide and shared by MOVE and DOOR; it SHALL be cleared on every state change.

Reset
REQ-027 rst=1 at an edge SHALL force state IDLE, floor=00, is_mooving=0, door_open=0, served=000 and counter=0.
REQ-028 Reset SHALL take priority over every other event, including mid-MOVE and mid-DOOR; the cabin returns to 00 with no served pulse.
REQ-029 A request present while rst=1 SHALL be ignored; it is evaluated on the first edge with rst=0.

Verification (TRAVEL_CYCLES=4, DOOR_CYCLES=8)
REQ-030 Scenario: reset, then req_valid=1 with open_when=01 at edge 0 -> is_mooving=1 at edge 0; floor=01, is_mooving=0, door_open=1 and served=010 at edge 4; door_open=0 at edge 12.
REQ-031 Scenario: at floor 00, request 10 -> floor=01 at edge 4 with is_mooving still 1; floor=10 and served=001 at edge 8.
REQ-032 Scenario: at floor 10, request 10 in IDLE -> door_open=1 and served=001 on the next edge; is_mooving stays 0.
REQ-033 Scenario: open_when switches 10->00 mid-MOVE toward 10 -> the cabin still arrives at 10 and served=001.
REQ-034 Scenario: rst pulsed during DOOR at floor 10 -> the next edge gives floor=00, door_open=0, served=000.
REQ-035 Scenario: open_when=11 with req_valid=1 in IDLE for 10 cycles -> all outputs unchanged; a random run checks that is_mooving&door_open==0 and served is one-hot or zero.

Source files
------------

// File: rtl/floor_controller.sv
// Three-floor cabin controller: accepts one request at a time from a
// scheduler, travels one floor per TRAVEL_CYCLES, holds the door open for
// DOOR_CYCLES and pulses a one-hot served code on arrival.
module floor_controller #(
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 8,
    parameter logic [1:0]  ST_FLOOR      = 2'b00,
    parameter logic [1:0]  ND_FLOOR      = 2'b01,
    parameter logic [1:0]  RD_FLOOR      = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] open_when,
    input  logic       req_valid,
    output logic [1:0] floor,
    output logic       is_mooving,
    output logic       door_open,
    output logic [2:0] served
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam logic [7:0] TRAVEL_LAST = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] DOOR_LAST   = 8'(DOOR_CYCLES - 1);
    localparam logic [1:0] BAD_FLOOR   = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] floor_q, floor_d;
    logic [1:0] target_q, target_d;
    logic [7:0] cnt_q, cnt_d;
    logic       moving_q, moving_d;
    logic       door_q, door_d;
    logic [2:0] served_q, served_d;
    logic [1:0] step_floor;

    // Served LED code {st,nd,rd} for a floor.
    function automatic logic [2:0] served_code(input logic [1:0] f);
        logic [2:0] code;
        code = 3'b000;
        if (f == ST_FLOOR)      code = 3'b100;
        else if (f == ND_FLOOR) code = 3'b010;
        else if (f == RD_FLOOR) code = 3'b001;
        return code;
    endfunction

    // State and output registers; reset dominates every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            floor_q  <= ST_FLOOR;
            target_q <= ST_FLOOR;
            cnt_q    <= '0;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            moving_q <= moving_d;
            door_q   <= door_d;
            served_q <= served_d;
        end
    end

    // Next-state logic: request acceptance, floor stepping and door timing.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        target_d   = target_q;
        cnt_d      = cnt_q;
        moving_d   = moving_q;
        door_d     = door_q;
        served_d   = '0;
        step_floor = (target_q > floor_q) ? floor_q + 2'd1 : floor_q - 2'd1;

        case (state_q)
            IDLE: begin
                if (req_valid && open_when != BAD_FLOOR) begin
                    cnt_d = '0;
                    if (open_when == floor_q) begin
                        state_d  = DOOR;
                        door_d   = 1'b1;
                        served_d = served_code(floor_q);
                    end else begin
                        state_d  = MOVE;
                        moving_d = 1'b1;
                        target_d = open_when;
                    end
                end
            end
            MOVE: begin
                if (cnt_q == TRAVEL_LAST) begin
                    cnt_d   = '0;
                    floor_d = step_floor;
                    if (step_floor == target_q) begin
                        state_d  = DOOR;
                        moving_d = 1'b0;
                        door_d   = 1'b1;
                        served_d = served_code(target_q);
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DOOR: begin
                if (cnt_q == DOOR_LAST) begin
                    state_d = IDLE;
                    door_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                moving_d = 1'b0;
                door_d   = 1'b0;
            end
        endcase
    end

    assign floor      = floor_q;
    assign is_mooving = moving_q;
    assign door_open  = door_q;
    assign served     = served_q;

endmodule

// File: tb/tb_floor_controller.sv
// Directed per-cycle vector table for the floor controller plus a random
// invariant run.
module tb_floor_controller;

    logic       clk;
    logic       rst;
    logic [1:0] open_when;
    logic       req_valid;
    logic [1:0] floor;
    logic       is_mooving;
    logic       door_open;
    logic [2:0] served;

    int tests;
    int fails;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [1:0]  ow;
        logic [1:0]  floor;
        logic        mov;
        logic        door;
        logic [2:0]  served;
        logic [63:0] tag;
    } vec_t;

    vec_t vecs[$];

    floor_controller #(
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .open_when (open_when),
        .req_valid (req_valid),
        .floor     (floor),
        .is_mooving(is_mooving),
        .door_open (door_open),
        .served    (served)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic rv, input logic [1:0] ow,
                       input logic [1:0] f, input logic m, input logic d,
                       input logic [2:0] s, input int n, input logic [63:0] tag);
        vec_t v;
        v.rst = r; v.rv = rv; v.ow = ow;
        v.floor = f; v.mov = m; v.door = d; v.served = s; v.tag = tag;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        open_when = 2'b00;
        tests = 0;
        fails = 0;

        // reset, request held during reset is ignored
        add(1, 0, 2'b00, 2'b00, 0, 0, 3'b000, 1, "RESET");
        add(1, 1, 2'b01, 2'b00, 0, 0, 3'b000, 1, "RSTREQ");
        // 00 -> 01: accept, 4 cycles travel, 8 cycles door
        add(0, 1, 2'b01, 2'b00, 1, 0, 3'b000, 1, "ACC01");
        add(0, 0, 2'b00, 2'b00, 1, 0, 3'b000, 3, "MV01");
        add(0, 0, 2'b00, 2'b01, 0, 1, 3'b010, 1, "ARR01");
        add(0, 0, 2'b00, 2'b01, 0, 1, 3'b000, 7, "DOOR01");
        // request while door falls is ignored
        add(0, 1, 2'b00, 2'b01, 0, 0, 3'b000, 1, "CLOSE01");
        // 01 -> 00 downward
        add(0, 1, 2'b00, 2'b01, 1, 0, 3'b000, 1, "ACC00");
        add(0, 0, 2'b00, 2'b01, 1, 0, 3'b000, 3, "MV00");
        add(0, 0, 2'b00, 2'b00, 0, 1, 3'b100, 1, "ARR00");
        add(0, 0, 2'b00, 2'b00, 0, 1, 3'b000, 7, "DOOR00");
        add(0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 1, "CLOSE00");
        // 00 -> 10 passing 01, request changes mid-move
        add(0, 1, 2'b10, 2'b00, 1, 0, 3'b000, 1, "ACC10");
        add(0, 1, 2'b00, 2'b00, 1, 0, 3'b000, 3, "MV10A");
        add(0, 1, 2'b00, 2'b01, 1, 0, 3'b000, 1, "PASS01");
        add(0, 1, 2'b00, 2'b01, 1, 0, 3'b000, 3, "MV10B");
        add(0, 0, 2'b00, 2'b10, 0, 1, 3'b001, 1, "ARR10");
        add(0, 0, 2'b00, 2'b10, 0, 1, 3'b000, 7, "DOOR10");
        add(0, 0, 2'b00, 2'b10, 0, 0, 3'b000, 1, "CLOSE10");
        // same-floor request, then reset mid-door
        add(0, 1, 2'b10, 2'b10, 0, 1, 3'b001, 1, "SAME10");
        add(0, 0, 2'b00, 2'b10, 0, 1, 3'b000, 3, "DOORS");
        add(1, 0, 2'b00, 2'b00, 0, 0, 3'b000, 1, "RSTDOOR");
        add(0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 1, "IDLE");
        // illegal target ignored
        add(0, 1, 2'b11, 2'b00, 0, 0, 3'b000, 10, "ILLEGAL");
        // reset mid-move after passing 01
        add(0, 1, 2'b10, 2'b00, 1, 0, 3'b000, 1, "ACCR");
        add(0, 0, 2'b00, 2'b00, 1, 0, 3'b000, 3, "MVR");
        add(0, 0, 2'b00, 2'b01, 1, 0, 3'b000, 2, "MVR01");
        add(1, 0, 2'b00, 2'b00, 0, 0, 3'b000, 1, "RSTMOVE");
        add(0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 2, "POSTRST");

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            req_valid = vecs[i].rv;
            open_when = vecs[i].ow;
            @(posedge clk);
            #1;
            tests++;
            if (floor !== vecs[i].floor || is_mooving !== vecs[i].mov ||
                door_open !== vecs[i].door || served !== vecs[i].served) begin
                fails++;
                $display("FAIL %0s row %0d: got floor=%b mov=%b door=%b served=%b, expected floor=%b mov=%b door=%b served=%b",
                         vecs[i].tag, i, floor, is_mooving, door_open, served,
                         vecs[i].floor, vecs[i].mov, vecs[i].door, vecs[i].served);
            end
        end

        // random run: structural invariants only
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            open_when = 2'($urandom_range(0, 3));
            rst       = ($urandom_range(0, 49) == 0);
            @(posedge clk);
            #1;
            tests++;
            if ((is_mooving & door_open) !== 1'b0 || floor === 2'b11 ||
                !(served == 3'b000 || served == 3'b001 || served == 3'b010 || served == 3'b100)) begin
                fails++;
                $display("FAIL invariant cycle %0d: got floor=%b mov=%b door=%b served=%b, required mov&door=0, floor!=11, served one-hot or zero",
                         c, floor, is_mooving, door_open, served);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
